// File: rtl/cuckoo_lookup_ctrl.sv
// Issue sequencer and result collector for one Cuckoo length-engine (case + nocase lanes).
// Follows each issued window through the fixed engine latency and queues qualified results.
module cuckoo_lookup_ctrl #(
  parameter int PIPE_LAT = 4,
  parameter int DEPTH    = 8,
  parameter int OFF_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             win_valid,
  input  logic             win_sop,
  input  logic             win_eop,
  output logic             win_rd,
  output logic             eng_enable,
  input  logic [1:0]       compare_out,
  input  logic [1:0]       suffix,
  input  logic [1:0]       compare_out_nocase,
  input  logic [1:0]       suffix_nocase,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [OFF_W-1:0] res_offset,
  output logic [1:0]       res_hit,
  output logic [1:0]       res_suf,
  output logic [1:0]       res_hit_nc,
  output logic [1:0]       res_suf_nc,
  output logic             res_eop,
  output logic             busy,
  output logic [15:0]      drop_cnt
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + PIPE_LAT + 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  typedef struct packed {
    logic [OFF_W-1:0] off;
    logic             eop;
  } tag_t;

  typedef struct packed {
    logic [OFF_W-1:0] off;
    logic [1:0]       hit;
    logic [1:0]       suf;
    logic [1:0]       hit_nc;
    logic [1:0]       suf_nc;
    logic             eop;
  } res_t;

  state_t            state, state_nxt;
  logic              issue, discard, credit_ok;
  logic [CW-1:0]     inflight, occ;
  logic [OFF_W-1:0]  off_cnt;
  tag_t              issue_tag;
  logic [PIPE_LAT:1] vld_pipe;
  tag_t [PIPE_LAT:1] tag_pipe;
  res_t              mem [DEPTH];
  logic [AW-1:0]     wp, rp;
  logic              push, pop;
  res_t              push_ent, shown;

  // Every window in the tracking pipe owns one queue slot until it is sampled.
  always_comb begin
    inflight = '0;
    for (int i = 1; i <= PIPE_LAT; i++) inflight = inflight + CW'(vld_pipe[i]);
  end

  assign credit_ok = (occ + inflight) < CW'(DEPTH);

  always_comb begin
    state_nxt = state;
    issue     = 1'b0;
    discard   = 1'b0;
    if (flush) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (win_valid) begin
            if (!win_sop) begin
              discard = 1'b1;
            end else if (credit_ok) begin
              issue     = 1'b1;
              state_nxt = win_eop ? DRAIN : RUN;
            end
          end
        end
        RUN: begin
          if (win_valid && credit_ok) begin
            issue = 1'b1;
            if (win_eop) state_nxt = DRAIN;
          end
        end
        DRAIN: begin
          if (inflight == '0) state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Gated by rst_n so the strobes drop asynchronously with the rest of the block.
  assign eng_enable = rst_n & issue;
  assign win_rd     = rst_n & (issue | discard);

  always_comb begin
    issue_tag.off = win_sop ? '0 : off_cnt;
    issue_tag.eop = win_eop;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      off_cnt  <= '0;
      drop_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (flush)      off_cnt <= '0;
      else if (issue) off_cnt <= issue_tag.off + OFF_W'(1);
      if (discard && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe <= '0;
      tag_pipe <= '0;
    end else if (flush) begin
      vld_pipe <= '0;
    end else begin
      vld_pipe <= {vld_pipe[PIPE_LAT-1:1], issue};
      tag_pipe <= {tag_pipe[PIPE_LAT-1:1], issue_tag};
    end
  end

  // The engine repeats its last lookup while idle; only a valid tail qualifies a sample.
  assign push = vld_pipe[PIPE_LAT] & ~flush &
                ((|compare_out) | (|compare_out_nocase) | tag_pipe[PIPE_LAT].eop);

  always_comb begin
    push_ent.off    = tag_pipe[PIPE_LAT].off;
    push_ent.hit    = compare_out;
    push_ent.suf    = suffix;
    push_ent.hit_nc = compare_out_nocase;
    push_ent.suf_nc = suffix_nocase;
    push_ent.eop    = tag_pipe[PIPE_LAT].eop;
  end

  assign res_valid = (occ != '0);
  assign pop       = res_valid & res_ready & ~flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp  <= '0;
      rp  <= '0;
      occ <= '0;
    end else if (flush) begin
      wp  <= '0;
      rp  <= '0;
      occ <= '0;
    end else begin
      if (push) wp <= wp + AW'(1);
      if (pop)  rp <= rp + AW'(1);
      case ({push, pop})
        2'b10:   occ <= occ + CW'(1);
        2'b01:   occ <= occ - CW'(1);
        default: occ <= occ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wp] <= push_ent;
  end

  assign shown      = res_valid ? mem[rp] : '0;
  assign res_offset = shown.off;
  assign res_hit    = shown.hit;
  assign res_suf    = shown.suf;
  assign res_hit_nc = shown.hit_nc;
  assign res_suf_nc = shown.suf_nc;
  assign res_eop    = shown.eop;

  assign busy = (state != IDLE) | (inflight != '0) | res_valid;

endmodule

// File: tb/tb_cuckoo_lookup_ctrl.sv
// Directed bench for cuckoo_lookup_ctrl: window FIFO + fixed-latency engine model,
// table-driven packet check plus hand-written multi-cycle sequences.
module tb_cuckoo_lookup_ctrl;
  localparam int PL    = 4;
  localparam int DEPTH = 8;
  localparam int OFF_W = 16;

  logic clk = 1'b0, rst_n = 1'b0, flush = 1'b0, res_ready = 1'b1;
  logic win_valid = 1'b0, win_sop = 1'b0, win_eop = 1'b0;
  logic [1:0] compare_out = '0, suffix = '0, compare_out_nocase = '0, suffix_nocase = '0;
  logic win_rd, eng_enable, res_valid, res_eop, busy;
  logic [1:0] res_hit, res_suf, res_hit_nc, res_suf_nc;
  logic [OFF_W-1:0] res_offset;
  logic [15:0] drop_cnt;

  always #5 clk = ~clk;

  cuckoo_lookup_ctrl #(.PIPE_LAT(PL), .DEPTH(DEPTH), .OFF_W(OFF_W)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .win_valid(win_valid), .win_sop(win_sop), .win_eop(win_eop), .win_rd(win_rd),
    .eng_enable(eng_enable),
    .compare_out(compare_out), .suffix(suffix),
    .compare_out_nocase(compare_out_nocase), .suffix_nocase(suffix_nocase),
    .res_valid(res_valid), .res_ready(res_ready), .res_offset(res_offset),
    .res_hit(res_hit), .res_suf(res_suf), .res_hit_nc(res_hit_nc), .res_suf_nc(res_suf_nc),
    .res_eop(res_eop), .busy(busy), .drop_cnt(drop_cnt)
  );

  typedef struct { logic sop; logic eop; logic [1:0] hit, suf, hnc, snc; } win_t;
  typedef struct { logic [15:0] off; logic [1:0] hit, suf, hnc, snc; logic eop; } ent_t;
  typedef struct { logic sop; logic eop; logic [1:0] hit, suf, hnc, snc; logic exp_push; } vec_t;

  win_t wq[$];
  ent_t got[$];
  int   iss[$];
  int   cyc = 0, en_cnt = 0, first_rv = -1;
  int   errors = 0, checks = 0;
  logic rd_seen = 1'b0, en_seen = 1'b0, force_cmp = 1'b0;
  logic [7:0] stg [1:PL];
  ent_t ent;
  vec_t tbl [6];

  // Edge monitor: pre-edge values of the DUT strobes and the accepted result entries.
  always @(posedge clk) begin
    cyc++;
    rd_seen = win_rd;
    en_seen = eng_enable;
    if (eng_enable) begin
      en_cnt++;
      iss.push_back(cyc);
    end
    if (res_valid && first_rv < 0) first_rv = cyc;
    if (res_valid && res_ready) begin
      ent.off = res_offset; ent.hit = res_hit; ent.suf = res_suf;
      ent.hnc = res_hit_nc; ent.snc = res_suf_nc; ent.eop = res_eop;
      got.push_back(ent);
    end
    if (rst_n && dut.push && !dut.pop && dut.occ == DEPTH) begin
      checks++;
      errors++;
      $display("FAIL queue_overflow: push into full queue at cycle %0d", cyc);
    end
  end

  // Window FIFO and engine: stage 1 loads on enable, later stages shift every clock.
  always @(negedge clk) begin
    for (int k = PL; k >= 2; k--) stg[k] = stg[k-1];
    if (en_seen && wq.size() > 0) stg[1] = {wq[0].hit, wq[0].suf, wq[0].hnc, wq[0].snc};
    if (rd_seen && wq.size() > 0) void'(wq.pop_front());
    rd_seen = 1'b0;
    en_seen = 1'b0;
    win_valid = (wq.size() > 0);
    win_sop   = (wq.size() > 0) ? wq[0].sop : 1'b0;
    win_eop   = (wq.size() > 0) ? wq[0].eop : 1'b0;
    compare_out        = force_cmp ? 2'b11 : stg[PL][7:6];
    suffix             = stg[PL][5:4];
    compare_out_nocase = force_cmp ? 2'b11 : stg[PL][3:2];
    suffix_nocase      = stg[PL][1:0];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic sop, input logic eop, input logic [1:0] hit,
                     input logic [1:0] suf, input logic [1:0] hnc, input logic [1:0] snc);
    win_t w;
    w.sop = sop; w.eop = eop; w.hit = hit; w.suf = suf; w.hnc = hnc; w.snc = snc;
    wq.push_back(w);
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_mon();
    got.delete();
    iss.delete();
    en_cnt   = 0;
    first_rv = -1;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    cycles(2);
    while ((wq.size() != 0 || busy) && n < 400) begin
      @(negedge clk);
      n++;
    end
    check({name, "_timeout"}, n < 400, 1);
    cycles(2);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_win_rd"}, win_rd, 0);
    check({tag, "_eng_enable"}, eng_enable, 0);
    check({tag, "_res_valid"}, res_valid, 0);
    check({tag, "_res_offset"}, res_offset, 0);
    check({tag, "_res_hit"}, {res_hit, res_hit_nc}, 0);
    check({tag, "_res_suf"}, {res_suf, res_suf_nc}, 0);
    check({tag, "_res_eop"}, res_eop, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_drop_cnt"}, drop_cnt, 0);
  endtask

  initial begin
    int k, n;
    // Packet exercising each qualification path; offsets equal the row index.
    tbl[0] = '{1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0};
    tbl[1] = '{1'b0, 1'b0, 2'b01, 2'b10, 2'b00, 2'b00, 1'b1};
    tbl[2] = '{1'b0, 1'b0, 2'b00, 2'b00, 2'b10, 2'b01, 1'b1};
    tbl[3] = '{1'b0, 1'b0, 2'b00, 2'b11, 2'b00, 2'b10, 1'b0};
    tbl[4] = '{1'b0, 1'b0, 2'b11, 2'b11, 2'b01, 2'b00, 1'b1};
    tbl[5] = '{1'b0, 1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 1'b1};
    for (int i = 1; i <= PL; i++) stg[i] = '0;

    #12;
    check_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Stray windows in IDLE are dropped without touching the engine.
    clear_mon();
    for (int i = 0; i < 3; i++) add(1'b0, 1'b0, 2'b01, 2'b00, 2'b00, 2'b00);
    cycles(10);
    check("stray_drop_cnt", drop_cnt, 3);
    check("stray_no_enable", en_cnt, 0);
    check("stray_popped", wq.size(), 0);
    check("stray_no_result", got.size(), 0);

    // Single packet: only offset 2 hits.
    clear_mon();
    add(1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00);
    add(1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00);
    add(1'b0, 1'b0, 2'b01, 2'b10, 2'b00, 2'b00);
    add(1'b0, 1'b1, 2'b00, 2'b00, 2'b00, 2'b00);
    wait_idle("single");
    check("single_enables", en_cnt, 4);
    check("single_entries", got.size(), 2);
    if (got.size() == 2) begin
      check("single_e0", {got[0].off, got[0].hit, got[0].suf, got[0].hnc, got[0].snc, got[0].eop},
            {16'd2, 2'b01, 2'b10, 2'b00, 2'b00, 1'b0});
      check("single_e1_off_eop", {got[1].off, got[1].eop}, {16'd3, 1'b1});
      check("single_e1_hits", {got[1].hit, got[1].hnc}, 0);
    end
    if (iss.size() >= 3) check("single_first_valid", first_rv, iss[2] + PL + 1);

    // Engine output stuck at hit with nothing in flight.
    clear_mon();
    force_cmp = 1'b1;
    cycles(20);
    check("idle_no_push", got.size(), 0);
    check("idle_res_valid", res_valid, 0);
    check("idle_busy", busy, 0);
    force_cmp = 1'b0;

    // Table-driven packet.
    clear_mon();
    for (int i = 0; i < 6; i++)
      add(tbl[i].sop, tbl[i].eop, tbl[i].hit, tbl[i].suf, tbl[i].hnc, tbl[i].snc);
    wait_idle("table");
    k = 0;
    for (int i = 0; i < 6; i++) begin
      if (tbl[i].exp_push) begin
        if (k < got.size())
          check($sformatf("table_row%0d", i),
                {got[k].off, got[k].hit, got[k].suf, got[k].hnc, got[k].snc, got[k].eop},
                {16'(i), tbl[i].hit, tbl[i].suf, tbl[i].hnc, tbl[i].snc, tbl[i].eop});
        k++;
      end
    end
    check("table_entries", got.size(), k);

    // Backpressure: credit limits issue to DEPTH windows.
    clear_mon();
    res_ready = 1'b0;
    for (int i = 0; i < 20; i++) add(i == 0, i == 19, 2'b01, 2'b00, 2'b00, 2'b00);
    cycles(30);
    check("bp_issues", en_cnt, DEPTH);
    check("bp_win_rd_low", win_rd, 0);
    check("bp_fifo_left", wq.size(), 20 - DEPTH);
    check("bp_res_valid", res_valid, 1);
    res_ready = 1'b1;
    wait_idle("bp");
    check("bp_entries", got.size(), 20);
    for (int i = 0; i < got.size(); i++) check($sformatf("bp_off%0d", i), got[i].off, i);
    if (got.size() == 20) check("bp_last_eop", got[19].eop, 1);

    // EOP immediately followed by the next packet's SOP.
    clear_mon();
    add(1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00);
    add(1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00);
    add(1'b0, 1'b1, 2'b00, 2'b00, 2'b00, 2'b00);
    add(1'b1, 1'b1, 2'b10, 2'b01, 2'b00, 2'b00);
    wait_idle("drain");
    check("drain_enables", en_cnt, 4);
    if (iss.size() >= 4) check("drain_gap_ok", (iss[3] - iss[2]) >= PL + 1, 1);
    check("drain_entries", got.size(), 2);
    if (got.size() == 2) begin
      check("drain_a_eop", {got[0].off, got[0].eop}, {16'd2, 1'b1});
      check("drain_b_sop", {got[1].off, got[1].hit, got[1].suf, got[1].eop},
            {16'd0, 2'b10, 2'b01, 1'b1});
    end

    // Flush with 2 queued and 3 in flight.
    clear_mon();
    res_ready = 1'b0;
    for (int i = 0; i < 5; i++) add(i == 0, 1'b0, 2'b01, 2'b00, 2'b00, 2'b00);
    n = 0;
    while (iss.size() == 0 && n < 50) begin @(negedge clk); n++; end
    while (iss.size() > 0 && cyc < iss[0] + 5 && n < 50) begin @(negedge clk); n++; end
    check("flush_setup_timeout", n < 50, 1);
    check("flush_pre_valid", res_valid, 1);
    check("flush_pre_busy", busy, 1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_res_valid", res_valid, 0);
    check("flush_busy", busy, 0);
    cycles(10);
    check("flush_no_late_push", res_valid, 0);
    check("flush_no_entries", got.size(), 0);
    res_ready = 1'b1;

    // Reset asserted mid-packet, between clock edges.
    clear_mon();
    res_ready = 1'b0;
    for (int i = 0; i < 7; i++) add(i == 0, 1'b0, 2'b01, 2'b00, 2'b00, 2'b00);
    cycles(8);
    check("rst_pre_valid", res_valid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("rst_mid");
    wq.delete();
    @(negedge clk);
    rst_n = 1'b1;
    res_ready = 1'b1;
    cycles(3);
    check("rst_after_busy", busy, 0);
    check("rst_after_valid", res_valid, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
